// File: rtl/spread_pkg.sv
// Shared widths and price type for the matching pipeline blocks.
package spread_pkg;

    localparam int DEF_PRICE_W = 8;
    localparam int DEF_CNT_W   = 16;

    typedef logic [DEF_PRICE_W-1:0] price_t;

endpackage

// File: rtl/spread.sv
// Registered bid/ask spread calculator: latches buy-sell on qualified matches.
module spread
    import spread_pkg::*;
#(
    parameter int PRICE_W = DEF_PRICE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRICE_W-1:0] buy_price,
    input  logic [PRICE_W-1:0] sell_price,
    input  logic               match_siganl,
    input  logic               enable_count,
    input  logic               halt_signal,
    output logic [PRICE_W-1:0] spread_now,
    output logic               spread_neg,
    output logic               spread_valid,
    output logic [CNT_W-1:0]   update_count
);

    logic               upd;
    logic [PRICE_W:0]   diff;

    logic [PRICE_W-1:0] spread_d, spread_q;
    logic               neg_d, neg_q;
    logic               valid_d, valid_q;
    logic [CNT_W-1:0]   count_d, count_q;

    // The extra top bit of the difference is the borrow, i.e. buy < sell.
    always_comb begin
        upd  = enable_count & match_siganl & ~halt_signal;
        diff = {1'b0, buy_price} - {1'b0, sell_price};

        spread_d = spread_q;
        neg_d    = neg_q;
        valid_d  = 1'b0;
        count_d  = count_q;

        if (upd) begin
            spread_d = diff[PRICE_W-1:0];
            neg_d    = diff[PRICE_W];
            valid_d  = 1'b1;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spread_q <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            spread_q <= spread_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign spread_now   = spread_q;
    assign spread_neg   = neg_q;
    assign spread_valid = valid_q;
    assign update_count = count_q;

endmodule

// File: tb/tb_spread.sv
// Directed self-checking bench for the spread calculator.
module tb_spread;

    logic        clk;
    logic        reset;
    logic [7:0]  buy_price;
    logic [7:0]  sell_price;
    logic        match_siganl;
    logic        enable_count;
    logic        halt_signal;
    logic [7:0]  spread_now;
    logic        spread_neg;
    logic        spread_valid;
    logic [15:0] update_count;

    int passed;
    int total;

    spread dut (
        .clk          (clk),
        .reset        (reset),
        .buy_price    (buy_price),
        .sell_price   (sell_price),
        .match_siganl (match_siganl),
        .enable_count (enable_count),
        .halt_signal  (halt_signal),
        .spread_now   (spread_now),
        .spread_neg   (spread_neg),
        .spread_valid (spread_valid),
        .update_count (update_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [7:0] s,
                             input logic n, input logic v,
                             input logic [15:0] c);
        check({tag, ".spread"}, 32'(spread_now), 32'(s));
        check({tag, ".neg"}, 32'(spread_neg), 32'(n));
        check({tag, ".valid"}, 32'(spread_valid), 32'(v));
        check({tag, ".count"}, 32'(update_count), 32'(c));
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        reset        = 1'b0;
        buy_price    = 8'd0;
        sell_price   = 8'd0;
        match_siganl = 1'b0;
        enable_count = 1'b0;
        halt_signal  = 1'b0;

        #1;
        check_all("reset_async", 8'd0, 1'b0, 1'b0, 16'd0);
        repeat (5) step();
        check_all("reset_hold", 8'd0, 1'b0, 1'b0, 16'd0);

        reset        = 1'b1;
        enable_count = 1'b0;
        match_siganl = 1'b1;
        buy_price    = 8'd80;
        sell_price   = 8'd70;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en0.valid", 32'(spread_valid), 32'd0);
        end
        check_all("en0", 8'd0, 1'b0, 1'b0, 16'd0);

        enable_count = 1'b1;
        match_siganl = 1'b0;
        buy_price    = 8'd75;
        sell_price   = 8'd74;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nomatch.valid", 32'(spread_valid), 32'd0);
        end
        check_all("nomatch", 8'd0, 1'b0, 1'b0, 16'd0);

        match_siganl = 1'b1;
        buy_price    = 8'd82;
        sell_price   = 8'd78;
        step();
        check_all("u82_78a", 8'd4, 1'b0, 1'b1, 16'd1);
        step();
        check_all("u82_78b", 8'd4, 1'b0, 1'b1, 16'd2);
        buy_price  = 8'd70;
        sell_price = 8'd65;
        step();
        check_all("u70_65a", 8'd5, 1'b0, 1'b1, 16'd3);
        step();
        check_all("u70_65b", 8'd5, 1'b0, 1'b1, 16'd4);
        buy_price  = 8'd60;
        sell_price = 8'd72;
        step();
        check_all("u60_72a", 8'd244, 1'b1, 1'b1, 16'd5);
        step();
        check_all("u60_72b", 8'd244, 1'b1, 1'b1, 16'd6);

        halt_signal = 1'b1;
        buy_price   = 8'd90;
        sell_price  = 8'd10;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("halt", 8'd244, 1'b1, 1'b0, 16'd6);
        end

        halt_signal  = 1'b0;
        match_siganl = 1'b0;
        buy_price    = 8'd88;
        sell_price   = 8'd11;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("unhalt_nomatch", 8'd244, 1'b1, 1'b0, 16'd6);
        end

        match_siganl = 1'b1;
        buy_price    = 8'd81;
        sell_price   = 8'd55;
        step();
        check_all("u81_55", 8'd26, 1'b0, 1'b1, 16'd7);

        // Mid-cycle input change must not reach the outputs.
        buy_price = 8'd200;
        #1;
        check("nocomb.spread", 32'(spread_now), 32'd26);
        buy_price  = 8'd50;
        sell_price = 8'd50;
        step();
        check_all("equal", 8'd0, 1'b0, 1'b1, 16'd8);

        buy_price  = 8'd3;
        sell_price = 8'd4;
        step();
        check_all("minus1", 8'd255, 1'b1, 1'b1, 16'd9);

        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 8'd0, 1'b0, 1'b0, 16'd0);
        step();
        check_all("rst_edge", 8'd0, 1'b0, 1'b0, 16'd0);

        reset      = 1'b1;
        buy_price  = 8'd100;
        sell_price = 8'd1;
        step();
        check_all("resume", 8'd99, 1'b0, 1'b1, 16'd1);
        step();
        check_all("resume2", 8'd99, 1'b0, 1'b1, 16'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
